// File: rtl/game_session_ctrl.sv
// Session controller: power-up game reset, Z-button debounce, vsync frame tick,
// and the boot/idle/serve/play/pause/over match FSM with per-player scoring.
module game_session_ctrl #(
    parameter int unsigned NUM_PLAYERS     = 2,
    parameter int unsigned RST_DELAY       = 2500000,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SCORE_W         = 8,
    parameter int unsigned WIN_SCORE       = 7,
    parameter int unsigned SERVE_FRAMES    = 60,
    localparam int unsigned PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                           clkin,
    input  logic                           rst,
    input  logic [NUM_PLAYERS-1:0]         btn_z,
    input  logic                           vsync,
    input  logic                           point_valid,
    input  logic [PW-1:0]                  point_player,
    output logic                           game_rst,
    output logic [2:0]                     state,
    output logic                           play_en,
    output logic [NUM_PLAYERS-1:0]         press,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [PW-1:0]                  winner,
    output logic                           winner_valid
);

    localparam int unsigned RD_W = $clog2(RST_DELAY + 1);
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned FR_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [2:0] S_BOOT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_SERVE = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;

    // Power-up delay: counter saturates at RST_DELAY, game_rst drops on that edge
    logic [RD_W-1:0] r_rst_cnt;
    logic            r_game_rst;
    logic            w_boot_done;

    assign w_boot_done = (r_rst_cnt == RD_W'(RST_DELAY));

    always_ff @(posedge clkin) begin
        if (!rst) begin
            r_rst_cnt  <= '0;
            r_game_rst <= 1'b1;
        end else if (w_boot_done) begin
            r_game_rst <= 1'b0;
        end else begin
            r_rst_cnt  <= r_rst_cnt + RD_W'(1);
        end
    end

    // Per-channel debounce; a press pulse is emitted together with a 0->1 level flip
    logic [NUM_PLAYERS-1:0] r_db_lvl;
    logic [NUM_PLAYERS-1:0] r_press;
    logic [DB_W-1:0]        r_db_cnt [NUM_PLAYERS];

    always_ff @(posedge clkin) begin
        if (!rst) begin
            r_db_lvl <= '0;
            r_press  <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) r_db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                r_press[i] <= 1'b0;
                if (btn_z[i] == r_db_lvl[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_db_lvl[i] <= btn_z[i];
                    r_db_cnt[i] <= '0;
                    r_press[i]  <= btn_z[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // vsync synchroniser plus edge-detect flop
    logic r_vs_meta, r_vs_sync, r_vs_prev;
    logic w_tick;

    always_ff @(posedge clkin) begin
        if (!rst) begin
            r_vs_meta <= 1'b0;
            r_vs_sync <= 1'b0;
            r_vs_prev <= 1'b0;
        end else begin
            r_vs_meta <= vsync;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
        end
    end

    assign w_tick = r_vs_sync & ~r_vs_prev;

    // Match FSM
    logic [2:0]         r_state, w_state_nxt;
    logic [FR_W-1:0]    r_frame, w_frame_nxt;
    logic [SCORE_W-1:0] r_score [NUM_PLAYERS];
    logic [SCORE_W-1:0] w_score_nxt [NUM_PLAYERS];
    logic [PW-1:0]      r_winner, w_winner_nxt;
    logic               r_play_en, r_win_valid;
    logic               w_any_press, w_point_ok;
    logic [SCORE_W-1:0] w_pt_score, w_pt_inc;

    assign w_any_press = |r_press;
    assign w_point_ok  = point_valid && ({1'b0, point_player} < (PW + 1)'(NUM_PLAYERS));

    always_comb begin
        w_pt_score = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (PW'(i) == point_player) w_pt_score = r_score[i];
        end
        w_pt_inc = (w_pt_score == '1) ? w_pt_score : w_pt_score + SCORE_W'(1);
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_frame_nxt  = r_frame;
        w_winner_nxt = r_winner;
        for (int i = 0; i < NUM_PLAYERS; i++) w_score_nxt[i] = r_score[i];

        case (r_state)
            S_BOOT: begin
                if (w_boot_done) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                for (int i = 0; i < NUM_PLAYERS; i++) w_score_nxt[i] = '0;
                if (w_any_press) begin
                    w_state_nxt = S_SERVE;
                    w_frame_nxt = '0;
                end
            end
            S_SERVE: begin
                if (w_tick) begin
                    w_frame_nxt = r_frame + FR_W'(1);
                    if (r_frame == FR_W'(SERVE_FRAMES - 1)) w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                // A valid point outranks a press arriving on the same cycle
                if (w_point_ok) begin
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (PW'(i) == point_player) w_score_nxt[i] = w_pt_inc;
                    end
                    if (w_pt_inc == SCORE_W'(WIN_SCORE)) begin
                        w_state_nxt  = S_OVER;
                        w_winner_nxt = point_player;
                    end else begin
                        w_state_nxt = S_SERVE;
                        w_frame_nxt = '0;
                    end
                end else if (w_any_press) begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (w_any_press) w_state_nxt = S_PLAY;
            end
            S_OVER: begin
                if (w_any_press) begin
                    w_state_nxt = S_IDLE;
                    for (int i = 0; i < NUM_PLAYERS; i++) w_score_nxt[i] = '0;
                end
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (!rst) begin
            r_state     <= S_BOOT;
            r_frame     <= '0;
            r_winner    <= '0;
            r_play_en   <= 1'b0;
            r_win_valid <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) r_score[i] <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame     <= w_frame_nxt;
            r_winner    <= w_winner_nxt;
            r_play_en   <= (w_state_nxt == S_PLAY);
            r_win_valid <= (w_state_nxt == S_OVER);
            for (int i = 0; i < NUM_PLAYERS; i++) r_score[i] <= w_score_nxt[i];
        end
    end

    assign game_rst     = r_game_rst;
    assign state        = r_state;
    assign play_en      = r_play_en;
    assign press        = r_press;
    assign winner       = r_winner;
    assign winner_valid = r_win_valid;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_scores
        assign scores[g*SCORE_W +: SCORE_W] = r_score[g];
    end

endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed-plus-random bench for game_session_ctrl against an event-level match model.
module tb_game_session_ctrl;

    localparam int NP  = 3;
    localparam int RD  = 10;
    localparam int DB  = 4;
    localparam int SW  = 8;
    localparam int WIN = 3;
    localparam int SF  = 2;
    localparam int PW  = 2;

    localparam int ST_BOOT  = 0;
    localparam int ST_IDLE  = 1;
    localparam int ST_SERVE = 2;
    localparam int ST_PLAY  = 3;
    localparam int ST_PAUSE = 4;
    localparam int ST_OVER  = 5;

    logic                 clkin = 1'b0;
    logic                 rst;
    logic [NP-1:0]        btn_z;
    logic                 vsync;
    logic                 point_valid;
    logic [PW-1:0]        point_player;
    logic                 game_rst;
    logic [2:0]           state;
    logic                 play_en;
    logic [NP-1:0]        press;
    logic [NP*SW-1:0]     scores;
    logic [PW-1:0]        winner;
    logic                 winner_valid;

    int n_assert = 0;
    int n_fail   = 0;

    // Match model: state, frames seen in SERVE, scores, winner
    int exp_state;
    int exp_frames;
    int exp_score [NP];
    int exp_winner;

    game_session_ctrl #(
        .NUM_PLAYERS(NP), .RST_DELAY(RD), .DEBOUNCE_CYCLES(DB),
        .SCORE_W(SW), .WIN_SCORE(WIN), .SERVE_FRAMES(SF)
    ) dut (
        .clkin(clkin), .rst(rst), .btn_z(btn_z), .vsync(vsync),
        .point_valid(point_valid), .point_player(point_player),
        .game_rst(game_rst), .state(state), .play_en(play_en), .press(press),
        .scores(scores), .winner(winner), .winner_valid(winner_valid)
    );

    always #5 clkin = ~clkin;

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_pulses(input int len);
        return (len >= DB) ? 1 : 0;
    endfunction

    task automatic model_press();
        case (exp_state)
            ST_IDLE:  begin exp_state = ST_SERVE; exp_frames = 0; end
            ST_PLAY:  exp_state = ST_PLAY + 1;
            ST_PAUSE: exp_state = ST_PLAY;
            ST_OVER: begin
                exp_state = ST_IDLE;
                for (int i = 0; i < NP; i++) exp_score[i] = 0;
            end
            default: ;
        endcase
    endtask

    task automatic model_tick();
        if (exp_state == ST_SERVE) begin
            exp_frames++;
            if (exp_frames == SF) exp_state = ST_PLAY;
        end
    endtask

    task automatic model_point(input int p);
        if (exp_state == ST_PLAY && p < NP) begin
            if (exp_score[p] < (1 << SW) - 1) exp_score[p]++;
            if (exp_score[p] == WIN) begin
                exp_state  = ST_OVER;
                exp_winner = p;
            end else begin
                exp_state  = ST_SERVE;
                exp_frames = 0;
            end
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "/state"}, 32'(state), 32'(exp_state));
        chk({tag, "/play_en"}, 32'(play_en), 32'(exp_state == ST_PLAY));
        chk({tag, "/winner_valid"}, 32'(winner_valid), 32'(exp_state == ST_OVER));
        for (int i = 0; i < NP; i++)
            chk($sformatf("%s/score%0d", tag, i), 32'(scores[i*SW +: SW]), 32'(exp_score[i]));
        if (exp_state == ST_OVER) chk({tag, "/winner"}, 32'(winner), 32'(exp_winner));
    endtask

    // Hold one button for len cycles, release, and count press pulses per channel
    task automatic press_btn(input int ch, input int len, output int n_ch, output int n_oth);
        n_ch  = 0;
        n_oth = 0;
        for (int k = 0; k < len + 8; k++) begin
            btn_z[ch] = (k < len);
            step();
            for (int i = 0; i < NP; i++) begin
                if (press[i] === 1'b1) begin
                    if (i == ch) n_ch++;
                    else n_oth++;
                end
            end
        end
    endtask

    task automatic do_press(input string tag, input int ch, input int len);
        int n_ch, n_oth;
        press_btn(ch, len, n_ch, n_oth);
        chk({tag, "/pulses"}, 32'(n_ch), 32'(exp_pulses(len)));
        chk({tag, "/other_pulses"}, 32'(n_oth), 32'(0));
        if (exp_pulses(len) == 1) model_press();
        chk_all(tag);
    endtask

    task automatic do_point(input string tag, input int p);
        point_valid  = 1'b1;
        point_player = PW'(p);
        step();
        point_valid  = 1'b0;
        step();
        model_point(p);
        chk_all(tag);
    endtask

    task automatic do_vs(input string tag);
        vsync = 1'b1;
        repeat (4) step();
        vsync = 1'b0;
        repeat (4) step();
        model_tick();
        chk_all(tag);
    endtask

    initial begin
        int n_ch, n_oth, ch, p, boot_pulses;
        logic [3:0] pat;

        rst          = 1'b0;
        btn_z        = '0;
        vsync        = 1'b0;
        point_valid  = 1'b0;
        point_player = '0;
        exp_state    = ST_BOOT;
        exp_frames   = 0;
        exp_winner   = 0;
        for (int i = 0; i < NP; i++) exp_score[i] = 0;

        repeat (3) step();
        chk("rst/game_rst", 32'(game_rst), 32'(1));
        chk("rst/press", 32'(press), 32'(0));
        chk("rst/winner", 32'(winner), 32'(0));
        chk_all("rst");

        // Boot window, with a long press on channel 0 that must not move the FSM
        rst = 1'b1;
        boot_pulses = 0;
        for (int k = 1; k <= RD; k++) begin
            btn_z[0] = (k <= 6);
            step();
            if (press[0] === 1'b1) boot_pulses++;
            chk($sformatf("boot%0d/game_rst", k), 32'(game_rst), 32'(1));
            chk($sformatf("boot%0d/state", k), 32'(state), 32'(ST_BOOT));
        end
        chk("boot/press_pulses", 32'(boot_pulses), 32'(exp_pulses(6)));
        step();
        exp_state = ST_IDLE;
        chk("boot_done/game_rst", 32'(game_rst), 32'(0));
        chk_all("boot_done");

        // Short presses and bounce never yield a pulse
        do_press("short3", 1, 3);
        for (int r = 0; r < 4; r++)
            do_press($sformatf("short_rand%0d", r), $urandom_range(0, NP - 1), $urandom_range(1, DB - 1));
        pat = 4'b1010;
        n_ch = 0;
        for (int k = 0; k < 12; k++) begin
            btn_z[1] = (k < 4) ? pat[3 - k] : 1'b0;
            step();
            if (press[1] === 1'b1) n_ch++;
        end
        chk("bounce/pulses", 32'(n_ch), 32'(0));
        chk_all("bounce");

        // Long press starts the serve; two frames reach PLAY
        do_press("serve_press", 2, $urandom_range(DB, DB + 4));
        do_vs("serve_tick1");
        do_vs("serve_tick2");

        // Point and press land on the same cycle: the point wins
        ch = $urandom_range(0, NP - 1);
        p  = $urandom_range(0, NP - 1);
        btn_z[ch] = 1'b1;
        repeat (DB) step();
        point_valid  = 1'b1;
        point_player = PW'(p);
        repeat (2) step();
        point_valid = 1'b0;
        btn_z[ch]   = 1'b0;
        repeat (8) step();
        model_point(p);
        chk_all("point_and_press");

        // Random match until someone reaches WIN_SCORE
        for (int it = 0; it < 100 && exp_state != ST_OVER; it++) begin
            if (exp_state == ST_SERVE) begin
                do_vs("rand_serve");
            end else if ($urandom_range(0, 9) == 0) begin
                do_press("pause_in", $urandom_range(0, NP - 1), DB + 1);
                do_vs("pause_tick");
                do_point("pause_point", $urandom_range(0, NP - 1));
                do_press("pause_out", $urandom_range(0, NP - 1), DB + 2);
            end else begin
                do_point($sformatf("rand_point%0d", it), $urandom_range(0, NP));
            end
        end
        chk("match/over", 32'(state), 32'(ST_OVER));
        do_point("over_point", 0);

        // Press in OVER returns to IDLE with cleared scores
        do_press("over_press", $urandom_range(0, NP - 1), DB);

        // Second match, then a mid-PLAY reset
        do_press("m2_serve", 0, DB);
        do_vs("m2_tick1");
        do_vs("m2_tick2");
        do_point("m2_pt1", 0);
        do_vs("m2_tick3");
        do_vs("m2_tick4");
        do_point("m2_pt2", 0);
        do_vs("m2_tick5");
        do_vs("m2_tick6");
        rst = 1'b0;
        step();
        exp_state = ST_BOOT;
        for (int i = 0; i < NP; i++) exp_score[i] = 0;
        chk("midrst/game_rst", 32'(game_rst), 32'(1));
        chk("midrst/press", 32'(press), 32'(0));
        chk_all("midrst");
        rst = 1'b1;
        repeat (RD + 1) step();
        exp_state = ST_IDLE;
        chk_all("reboot");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
